// File: rtl/custom_reg_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : custom_reg_bank_if
// Purpose  : Register-side write bus and IP-side snapshot handshake bundle.
// Revision : 1.0
// ============================================================================
interface custom_reg_bank_if #(
    parameter int NUM_CH = 3,
    parameter int DW     = 32
);
    logic [NUM_CH-1:0]    reg2ip_we_i;
    logic [NUM_CH*DW-1:0] reg2ip_wdata_i;
    logic [2*NUM_CH-1:0]  reg2ip_mode_i;
    logic [NUM_CH-1:0]    reg2ip_ovf_clr_i;
    logic [NUM_CH-1:0]    reg2ip_ack_o;
    logic [NUM_CH*DW-1:0] ip2reg_data_o;
    logic [NUM_CH-1:0]    ip2reg_valid_o;
    logic [NUM_CH-1:0]    ip2reg_ready_i;
    logic [NUM_CH-1:0]    ip2reg_ovf_o;

    modport master (
        output reg2ip_we_i, reg2ip_wdata_i, reg2ip_mode_i, reg2ip_ovf_clr_i, ip2reg_ready_i,
        input  reg2ip_ack_o, ip2reg_data_o, ip2reg_valid_o, ip2reg_ovf_o
    );

    modport slave (
        input  reg2ip_we_i, reg2ip_wdata_i, reg2ip_mode_i, reg2ip_ovf_clr_i, ip2reg_ready_i,
        output reg2ip_ack_o, ip2reg_data_o, ip2reg_valid_o, ip2reg_ovf_o
    );
endinterface
`default_nettype wire

// File: rtl/custom_reg_bank.sv
`default_nettype none
// ============================================================================
// Module   : custom_reg_bank
// Purpose  : Per-channel read-modify-write registers with snapshot handshake.
// Revision : 1.0
// ============================================================================
module custom_reg_bank #(
    parameter int NUM_CH = 3,
    parameter int DW     = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    custom_reg_bank_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_PEND  = 2'd2
    } state_e;

    logic [DW-1:0]        reg_q   [NUM_CH];
    logic [DW-1:0]        reg_d   [NUM_CH];
    state_e               state_q [NUM_CH];
    state_e               state_d [NUM_CH];
    logic [NUM_CH*DW-1:0] data_q, data_d;
    logic [NUM_CH-1:0]    valid_q, valid_d;
    logic [NUM_CH-1:0]    ack_q, ack_d;
    logic [NUM_CH-1:0]    ovf_q, ovf_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = bus.reg2ip_we_i;
        ovf_d   = ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            logic [DW-1:0] wdata_c;
            logic [DW-1:0] calc_c;
            logic          we_c;
            logic          rdy_c;
            logic          ovf_set_c;

            wdata_c   = bus.reg2ip_wdata_i[c*DW +: DW];
            we_c      = bus.reg2ip_we_i[c];
            rdy_c     = bus.ip2reg_ready_i[c];
            ovf_set_c = 1'b0;

            case (bus.reg2ip_mode_i[2*c +: 2])
                2'b00:   calc_c = wdata_c;
                2'b01:   calc_c = reg_q[c] + wdata_c;
                2'b10:   calc_c = reg_q[c] | wdata_c;
                default: calc_c = reg_q[c] & ~wdata_c;
            endcase
            reg_d[c]   = we_c ? calc_c : reg_q[c];
            state_d[c] = state_q[c];

            // Snapshot always captures reg_d so a same-edge write is never lost.
            case (state_q[c])
                ST_IDLE: begin
                    if (we_c) begin
                        state_d[c]               = ST_VALID;
                        data_d[c*DW +: DW]       = reg_d[c];
                    end
                end
                ST_VALID: begin
                    if (rdy_c) begin
                        if (we_c) data_d[c*DW +: DW] = reg_d[c];
                        else      state_d[c]         = ST_IDLE;
                    end else if (we_c) begin
                        state_d[c] = ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (rdy_c) begin
                        state_d[c]         = ST_VALID;
                        data_d[c*DW +: DW] = reg_d[c];
                    end else if (we_c) begin
                        ovf_set_c = 1'b1;
                    end
                end
                default: state_d[c] = ST_IDLE;
            endcase

            valid_d[c] = (state_d[c] != ST_IDLE);
            ovf_d[c]   = ovf_set_c | (ovf_q[c] & ~bus.reg2ip_ovf_clr_i[c]);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                reg_q[c]   <= '0;
                state_q[c] <= ST_IDLE;
            end
            data_q  <= '0;
            valid_q <= '0;
            ack_q   <= '0;
            ovf_q   <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                reg_q[c]   <= reg_d[c];
                state_q[c] <= state_d[c];
            end
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.reg2ip_ack_o   = ack_q;
    assign bus.ip2reg_data_o  = data_q;
    assign bus.ip2reg_valid_o = valid_q;
    assign bus.ip2reg_ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: doc/custom_reg_bank.md
CUSTOM_REG_BANK -- requirements
Module: custom_reg_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of independent register channels, legal range 1..16.
REQ-002 SHALL have parameter DW, default 32: data width per channel, legal range 1..64.
REQ-003 SHALL have port clk_i, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port reg2ip_we_i, input, NUM_CH: per-channel write strobe.
REQ-006 SHALL have port reg2ip_wdata_i, input, NUM_CH*DW: write data, channel c at bits [c*DW +: DW].
REQ-007 SHALL have port reg2ip_mode_i, input, 2*NUM_CH: per-channel write mode, channel c at bits [2c +: 2].
REQ-008 SHALL have port reg2ip_ovf_clr_i, input, NUM_CH: per-channel overflow-flag clear.
REQ-009 SHALL have port reg2ip_ack_o, output, NUM_CH: per-channel write acknowledge pulse.
REQ-010 SHALL have port ip2reg_data_o, output, NUM_CH*DW: per-channel snapshot data, same packing as wdata.
REQ-011 SHALL have port ip2reg_valid_o, output, NUM_CH: snapshot valid.
REQ-012 SHALL have port ip2reg_ready_i, input, NUM_CH: consumer ready.
REQ-013 SHALL have port ip2reg_ovf_o, output, NUM_CH: sticky lost-update flag.

Function
REQ-014 SHALL keep one DW-bit register reg[c] per channel; channels fully independent.
REQ-015 SHALL compute reg_next[c] when we[c]=1 per mode: 00 replace with wdata; 01 reg+wdata modulo 2^DW (carry discarded, wraps); 10 reg OR wdata; 11 reg AND NOT wdata; reg_next[c]=reg[c] when we[c]=0.
REQ-016 SHALL load reg[c]<=reg_next[c] on the edge at which we[c]=1 (zero-cycle write latency).
REQ-017 SHALL assert reg2ip_ack_o[c] for exactly one cycle, the cycle after each edge with we[c]=1; back-to-back writes give continuous ack.
REQ-018 SHALL run per-channel FSM with states IDLE, VALID, PEND; valid_o[c]=1 in VALID and PEND.
REQ-019 IDLE: we=1 -> VALID, data_o<=reg_next; else stay.
REQ-020 VALID: ready=1,we=0 -> IDLE; ready=1,we=1 -> VALID, data_o<=reg_next; ready=0,we=1 -> PEND, data_o held; ready=0,we=0 -> hold.
REQ-021 PEND: ready=1 -> VALID, data_o<=reg_next (latest value incl. same-edge write); ready=0,we=1 -> stay PEND, set ovf[c]; ready=0,we=0 -> hold.
REQ-022 SHALL keep data_o[c] stable while valid_o[c]=1 and ready_i[c]=0.
REQ-023 SHALL clear ovf[c] on edge with ovf_clr[c]=1; if set and clear coincide, set wins.
REQ-024 SHALL treat ready_i[c] as don't-care in IDLE.

Reset
REQ-025 SHALL, while rst_i=1, force all reg to 0, all states IDLE, data_o=0, valid_o=0, ack_o=0, ovf_o=0, without waiting for a clock edge.
REQ-026 SHALL discard any in-flight write, ack or pending snapshot when reset asserts mid-operation; first write after deassertion behaves as from IDLE.

Verification
REQ-027 Replace: ch0 mode 00, we=1, wdata=0xA5A5A5A5, ready=1 -> next cycle ack[0]=1, valid[0]=1, data0=0xA5A5A5A5; following cycle valid[0]=0, ack[0]=0.
REQ-028 Accumulate wrap: ch1 reg=0xFFFFFFF0, mode 01, wdata=0x20 -> reg1=0x00000010, data1=0x00000010, no other flag.
REQ-029 Set/clear: ch2 reg=0x0F, mode 10 wdata=0xF0 -> 0xFF; then mode 11 wdata=0x0F -> 0xF0; data2 tracks each value.
REQ-030 Backpressure: ch0 ready=0, writes 1, 2, 3 on consecutive cycles -> data0 stays 1, state PEND, ovf[0]=1 after third write; raise ready -> next cycle data0=3, valid=1; ovf_clr -> ovf[0]=0.
REQ-031 Simultaneous: VALID with ready=1 and we=1 (data 0x55) same edge -> valid stays 1, data=0x55, ack pulses; ovf_clr and ovf set same edge -> ovf=1.
REQ-032 Async reset: assert rst_i mid-cycle while PEND with ovf=1 -> all outputs 0 before next edge; NUM_CH=1, DW=8 build passes REQ-027..REQ-030 scaled to 8 bits.
